// File: rtl/serial_in.sv
// -----------------------------------------------------------------------------
// serial_in
//
// Serial deserializer/loader for the feature-data path. A bit stream arrives on
// `ser`, one bit per rising CLK edge, LSB first. Every 16 bits form a word that
// is written into a data-point x feature memory. Within a data point, features
// arrive from index `feat` down to 0. Data points arrive in ascending order
// 0 .. num_dp-1. `done` rises once the last word is stored and then stays high.
//
// Ports:
//   CLK       in   system clock, rising-edge active
//   RST       in   asynchronous active-low reset
//   ser       in   serial data bit
//   num_dp    in   number of data points to receive (0..7)
//   feat      in   index of the last feature (features per point = feat+1)
//   done      out  dataset complete; sticky until reset
//   word_stb  out  one-cycle pulse following each word write
//   rd_dp     in   read address, data-point index
//   rd_feat   in   read address, feature index
//   rd_data   out  combinational read of mem[rd_dp][rd_feat] (0 when out of range)
// -----------------------------------------------------------------------------
module serial_in #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_DP     = 7,
    parameter int MAX_FEAT   = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ser,
    input  logic [2:0]            num_dp,
    input  logic [4:0]            feat,
    output logic                  done,
    output logic                  word_stb,
    input  logic [2:0]            rd_dp,
    input  logic [4:0]            rd_feat,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int BW = $clog2(DATA_WIDTH);

    // Control and datapath state
    logic                  started_q,  started_d;
    logic [2:0]            num_dp_q,   num_dp_d;
    logic [4:0]            feat_q,     feat_d;
    logic [BW-1:0]         bit_cnt_q,  bit_cnt_d;
    logic [4:0]            feat_cnt_q, feat_cnt_d;
    logic [2:0]            dp_cnt_q,   dp_cnt_d;
    logic [DATA_WIDTH-1:0] sr_q,       sr_d;
    logic                  done_q,     done_d;
    logic                  stb_q,      stb_d;

    // Effective configuration/counter values. Configuration is captured on the
    // first edge after reset release, and that same edge already samples bit 0,
    // so until capture the live inputs stand in for the registered copies.
    logic [2:0]            num_eff;
    logic [4:0]            feat_eff;
    logic [4:0]            fcnt_eff;
    logic                  active;
    logic                  last_bit;
    logic                  wr_en;
    logic                  last_word;
    logic [DATA_WIDTH-1:0] wr_word;

    // Storage: not reset; unwritten locations read as don't-care.
    logic [DATA_WIDTH-1:0] mem [MAX_DP][MAX_FEAT];

    always_comb begin
        num_eff   = started_q ? num_dp_q   : num_dp;
        feat_eff  = started_q ? feat_q     : feat;
        fcnt_eff  = started_q ? feat_cnt_q : feat;

        // Nothing is received once done, or when no data points are requested.
        active    = !done_q && (num_eff != 3'd0);
        last_bit  = (bit_cnt_q == BW'(DATA_WIDTH - 1));
        wr_en     = active && last_bit;
        wr_word   = {ser, sr_q[DATA_WIDTH-1:1]};
        last_word = wr_en && (fcnt_eff == 5'd0) && (dp_cnt_q == num_eff - 3'd1);
    end

    always_comb begin
        started_d  = 1'b1;
        num_dp_d   = started_q ? num_dp_q : num_dp;
        feat_d     = started_q ? feat_q   : feat;
        bit_cnt_d  = bit_cnt_q;
        feat_cnt_d = fcnt_eff;
        dp_cnt_d   = dp_cnt_q;
        sr_d       = sr_q;
        stb_d      = wr_en;
        done_d     = done_q || last_word || (num_eff == 3'd0);

        if (active) begin
            sr_d      = wr_word;
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + BW'(1);
            if (wr_en) begin
                if (fcnt_eff == 5'd0) begin
                    // Feature 0 closes a data point: reload and advance.
                    feat_cnt_d = feat_eff;
                    dp_cnt_d   = dp_cnt_q + 3'd1;
                end else begin
                    feat_cnt_d = fcnt_eff - 5'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            started_q  <= 1'b0;
            num_dp_q   <= '0;
            feat_q     <= '0;
            bit_cnt_q  <= '0;
            feat_cnt_q <= '0;
            dp_cnt_q   <= '0;
            sr_q       <= '0;
            done_q     <= 1'b0;
            stb_q      <= 1'b0;
        end else begin
            started_q  <= started_d;
            num_dp_q   <= num_dp_d;
            feat_q     <= feat_d;
            bit_cnt_q  <= bit_cnt_d;
            feat_cnt_q <= feat_cnt_d;
            dp_cnt_q   <= dp_cnt_d;
            sr_q       <= sr_d;
            done_q     <= done_d;
            stb_q      <= stb_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[dp_cnt_q][fcnt_eff] <= wr_word;
        end
    end

    // Read port: a same-cycle write to the addressed location shows up only
    // after the edge, so this naturally returns the old value.
    always_comb begin
        rd_data = '0;
        if ((int'(rd_dp) < MAX_DP) && (int'(rd_feat) < MAX_FEAT)) begin
            rd_data = mem[rd_dp][rd_feat];
        end
    end

    assign done     = done_q;
    assign word_stb = stb_q;

endmodule

// File: tb/tb_serial_in.sv
module tb_serial_in;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ser;
    logic [2:0]  num_dp;
    logic [4:0]  feat;
    logic        done;
    logic        word_stb;
    logic [2:0]  rd_dp;
    logic [4:0]  rd_feat;
    logic [15:0] rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] tx_q[$];
    logic [15:0] exp_mem [7][32];
    int          stb_cnt;
    int          done_edge;

    always #5 CLK = ~CLK;

    serial_in dut (
        .CLK      (CLK),
        .RST      (RST),
        .ser      (ser),
        .num_dp   (num_dp),
        .feat     (feat),
        .done     (done),
        .word_stb (word_stb),
        .rd_dp    (rd_dp),
        .rd_feat  (rd_feat),
        .rd_data  (rd_data)
    );

    // Reference model: the k-th word sent belongs to data point k/(feat+1) and
    // feature feat - k%(feat+1).
    task automatic build_expect(input int nf);
        for (int k = 0; k < tx_q.size(); k++) begin
            exp_mem[k / (nf + 1)][nf - (k % (nf + 1))] = tx_q[k];
        end
    endtask

    // Called at #1 after a rising edge; release lands mid-cycle.
    task automatic apply_reset(input logic [2:0] nd, input logic [4:0] nf);
        RST    = 1'b0;
        num_dp = nd;
        feat   = nf;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    // Drives tx_q bit-serially (LSB first) and measures strobes and done edge.
    task automatic send_stream(input bit scramble);
        int n;
        logic [15:0] w;
        n         = 0;
        stb_cnt   = 0;
        done_edge = -1;
        for (int i = 0; i < tx_q.size(); i++) begin
            w = tx_q[i];
            for (int b = 0; b < 16; b++) begin
                ser = w[b];
                @(posedge CLK);
                #1;
                n++;
                if (word_stb === 1'b1) stb_cnt++;
                if (done === 1'b1 && done_edge < 0) done_edge = n;
                if (scramble && n == 1) begin
                    num_dp = 3'($urandom);
                    feat   = 5'($urandom);
                end
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        RST = 1'b0;
        num_dp = 3'd0;
        feat = 5'd0;
        rd_dp = 3'd0;
        rd_feat = 5'd0;
        ser = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ser = 1'($urandom);
            @(posedge CLK);
            #1;
            if (done !== 1'b0 || word_stb !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL reset_hold: %0d cycles with done/word_stb high, required 0", bad);
        end
        RST = 1'b1;
        #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL release_no_edge: done=%b required 0", done);
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL num_dp0_done: done=%b required 1", done);
        end
        bad = 0;
        repeat (5) begin
            ser = 1'($urandom);
            @(posedge CLK);
            #1;
            if (word_stb !== 1'b0 || done !== 1'b1) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL num_dp0_idle: %0d bad cycles, required 0", bad);
        end
    endtask

    task automatic test_single_word();
        apply_reset(3'd1, 5'd0);
        tx_q = '{16'hA5C3};
        build_expect(0);
        send_stream(1'b0);
        n_checks++;
        if (stb_cnt !== 1) begin
            n_fail++;
            $display("FAIL single_stb: got %0d pulses, required 1", stb_cnt);
        end
        n_checks++;
        if (done_edge !== 16) begin
            n_fail++;
            $display("FAIL single_done: done at edge %0d, required 16", done_edge);
        end
        rd_dp = 3'd0;
        rd_feat = 5'd0;
        #1;
        n_checks++;
        if (rd_data !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL single_mem: got %h, required a5c3", rd_data);
        end
    endtask

    task automatic test_feature_order();
        apply_reset(3'd1, 5'd2);
        tx_q = '{16'h1111, 16'h2222, 16'h3333};
        build_expect(2);
        send_stream(1'b0);
        n_checks++;
        if (done_edge !== 48) begin
            n_fail++;
            $display("FAIL feat_done: done at edge %0d, required 48", done_edge);
        end
        for (int f = 0; f < 3; f++) begin
            rd_dp = 3'd0;
            rd_feat = 5'(f);
            #1;
            n_checks++;
            if (rd_data !== exp_mem[0][f]) begin
                n_fail++;
                $display("FAIL feat_mem[0][%0d]: got %h, required %h", f, rd_data, exp_mem[0][f]);
            end
        end
    endtask

    task automatic test_full_dataset();
        logic [7:0] di, fj;
        apply_reset(3'd5, 5'd11);
        tx_q = {};
        for (int i = 0; i < 5; i++) begin
            for (int j = 11; j >= 0; j--) begin
                di = 8'(i);
                fj = 8'(j);
                tx_q.push_back({di, fj});
            end
        end
        build_expect(11);
        send_stream(1'b0);
        n_checks++;
        if (stb_cnt !== 60) begin
            n_fail++;
            $display("FAIL full_stb: got %0d pulses, required 60", stb_cnt);
        end
        n_checks++;
        if (done_edge !== 960) begin
            n_fail++;
            $display("FAIL full_done: done at edge %0d, required 960", done_edge);
        end
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 12; j++) begin
                rd_dp = 3'(i);
                rd_feat = 5'(j);
                #1;
                n_checks++;
                if (rd_data !== exp_mem[i][j]) begin
                    n_fail++;
                    $display("FAIL full_mem[%0d][%0d]: got %h, required %h", i, j, rd_data, exp_mem[i][j]);
                end
            end
        end
        rd_dp = 3'd7;
        rd_feat = 5'd0;
        #1;
        n_checks++;
        if (rd_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL oor_read: got %h, required 0000", rd_data);
        end
    endtask

    task automatic test_post_done();
        int stb_extra;
        int bad;
        stb_extra = 0;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            ser = 1'($urandom);
            @(posedge CLK);
            #1;
            if (word_stb === 1'b1) stb_extra++;
            if (done !== 1'b1) bad++;
        end
        n_checks++;
        if (stb_extra !== 0) begin
            n_fail++;
            $display("FAIL post_stb: got %0d pulses, required 0", stb_extra);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL post_done: done low on %0d cycles, required 0", bad);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 12; j++) begin
                rd_dp = 3'(i);
                rd_feat = 5'(j);
                #1;
                if (rd_data !== exp_mem[i][j]) bad++;
            end
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL post_mem: %0d words changed, required 0", bad);
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [15:0] w;
        // done is high from the previous dataset; reset must drop it without an edge.
        #2;
        RST = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear_done: done=%b required 0", done);
        end
        @(posedge CLK);
        #1;
        apply_reset(3'd2, 5'd1);
        w = 16'($urandom);
        for (int b = 0; b < 20; b++) begin
            ser = (b < 16) ? w[b] : 1'($urandom);
            @(posedge CLK);
            #1;
        end
        #3;
        RST = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0 || word_stb !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_abort: done=%b stb=%b required 0 0", done, word_stb);
        end
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        tx_q = {};
        for (int k = 0; k < 4; k++) tx_q.push_back(16'($urandom));
        build_expect(1);
        send_stream(1'b0);
        n_checks++;
        if (done_edge !== 64) begin
            n_fail++;
            $display("FAIL mid_done: done at edge %0d, required 64", done_edge);
        end
        n_checks++;
        if (stb_cnt !== 4) begin
            n_fail++;
            $display("FAIL mid_stb: got %0d pulses, required 4", stb_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                rd_dp = 3'(i);
                rd_feat = 5'(j);
                #1;
                n_checks++;
                if (rd_data !== exp_mem[i][j]) begin
                    n_fail++;
                    $display("FAIL mid_mem[%0d][%0d]: got %h, required %h", i, j, rd_data, exp_mem[i][j]);
                end
            end
        end
    endtask

    task automatic test_random_config();
        int nd, nf, bad;
        for (int it = 0; it < 3; it++) begin
            nd = $urandom_range(1, 7);
            nf = $urandom_range(0, 15);
            apply_reset(3'(nd), 5'(nf));
            tx_q = {};
            for (int k = 0; k < nd * (nf + 1); k++) tx_q.push_back(16'($urandom));
            build_expect(nf);
            // Configuration inputs are scrambled after capture and must be ignored.
            send_stream(1'b1);
            n_checks++;
            if (done_edge !== nd * (nf + 1) * 16) begin
                n_fail++;
                $display("FAIL rand_done nd=%0d nf=%0d: edge %0d, required %0d", nd, nf, done_edge, nd * (nf + 1) * 16);
            end
            n_checks++;
            if (stb_cnt !== nd * (nf + 1)) begin
                n_fail++;
                $display("FAIL rand_stb nd=%0d nf=%0d: got %0d, required %0d", nd, nf, stb_cnt, nd * (nf + 1));
            end
            bad = 0;
            for (int i = 0; i < nd; i++) begin
                for (int j = 0; j <= nf; j++) begin
                    rd_dp = 3'(i);
                    rd_feat = 5'(j);
                    #1;
                    if (rd_data !== exp_mem[i][j]) bad++;
                end
            end
            n_checks++;
            if (bad !== 0) begin
                n_fail++;
                $display("FAIL rand_mem nd=%0d nf=%0d: %0d wrong words, required 0", nd, nf, bad);
            end
        end
    endtask

    initial begin
        RST = 1'b0;
        ser = 1'b0;
        num_dp = 3'd0;
        feat = 5'd0;
        rd_dp = 3'd0;
        rd_feat = 5'd0;
        test_reset();
        test_single_word();
        test_feature_order();
        test_full_dataset();
        test_post_done();
        test_reset_mid_stream();
        test_random_config();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
